// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the PC sequencer and its memory/datapath.
// The slave modport is the sequencer's view of the bundle.
interface pc_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              en;
  logic              mem_rdy;
  logic [ADDR_W-1:0] mem_data;
  logic              leq;
  logic              load;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_req;
  logic [1:0]        opsel;
  logic              exec;
  logic              halted;
  logic              wrap;

  modport slave (
    input  en, mem_rdy, mem_data, leq, load, load_addr,
    output pc, fetch_addr, fetch_req, opsel, exec, halted, wrap
  );

  modport master (
    output en, mem_rdy, mem_data, leq, load, load_addr,
    input  pc, fetch_addr, fetch_req, opsel, exec, halted, wrap
  );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction sequencer for a three-operand subtract-and-branch machine:
// fetches A, B, C, pulses EXEC, then steps or branches the PC.
module pc_sequencer #(
  parameter int                     ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]      RESET_PC  = '0,
  parameter int unsigned            STEP      = 3,
  parameter logic [ADDR_W-1:0]      HALT_ADDR = '1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_EXECUTE,
    S_UPDATE,
    S_HALT
  } state_t;

  localparam logic [ADDR_W:0] STEP_X = (ADDR_W+1)'(STEP);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_c;
  logic              r_wrap;
  logic              r_run;

  logic              w_adv;
  logic [ADDR_W:0]   w_sum;

  // r_run keeps the first fetch request off until one edge after reset release
  assign w_adv = r_run & bus.en & bus.mem_rdy;
  assign w_sum = {1'b0, r_pc} + STEP_X;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH_A;
      r_pc    <= RESET_PC;
      r_c     <= '0;
      r_wrap  <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (bus.load) begin
        r_pc    <= bus.load_addr;
        r_state <= S_FETCH_A;
        r_wrap  <= 1'b0;
      end else begin
        case (r_state)
          S_FETCH_A: if (w_adv) r_state <= S_FETCH_B;
          S_FETCH_B: if (w_adv) r_state <= S_FETCH_C;
          S_FETCH_C: begin
            if (w_adv) begin
              r_c     <= bus.mem_data;
              r_state <= S_EXECUTE;
            end
          end
          S_EXECUTE: if (bus.en) r_state <= S_UPDATE;
          S_UPDATE: begin
            if (bus.en) begin
              if (bus.leq) begin
                r_pc    <= r_c;
                r_state <= (r_c == HALT_ADDR) ? S_HALT : S_FETCH_A;
              end else begin
                r_pc    <= w_sum[ADDR_W-1:0];
                r_state <= S_FETCH_A;
                if (w_sum[ADDR_W]) r_wrap <= 1'b1;
              end
            end
          end
          default: r_state <= S_HALT;
        endcase
      end
    end
  end

  always_comb begin
    bus.pc         = r_pc;
    bus.fetch_addr = r_pc;
    bus.fetch_req  = 1'b0;
    bus.opsel      = 2'd3;
    bus.exec       = 1'b0;
    bus.halted     = (r_state == S_HALT);
    bus.wrap       = r_wrap;
    if (r_run) begin
      case (r_state)
        S_FETCH_A: begin
          bus.fetch_req = bus.en;
          bus.opsel     = 2'd0;
        end
        S_FETCH_B: begin
          bus.fetch_req  = bus.en;
          bus.opsel      = 2'd1;
          bus.fetch_addr = r_pc + ADDR_W'(1);
        end
        S_FETCH_C: begin
          bus.fetch_req  = bus.en;
          bus.opsel      = 2'd2;
          bus.fetch_addr = r_pc + ADDR_W'(2);
        end
        S_EXECUTE: bus.exec = bus.en;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a progress-counter model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pc_sequencer;

  localparam int STEP_M = 3;
  localparam int HALT_M = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(8)) bus ();

  pc_sequencer #(
    .ADDR_W   (8),
    .RESET_PC (8'h00),
    .STEP     (3),
    .HALT_ADDR(8'hFF)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: instruction progress 0..4 = operands fetched so far, then execute, then update
  int m_pc = 0, m_c = 0, m_step = 0;
  bit m_wrap = 0, m_halted = 0, m_run = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_c = 0; m_step = 0; m_wrap = 0; m_halted = 0; m_run = 0;
    end else begin
      if (bus.load) begin
        m_pc = int'(bus.load_addr); m_step = 0; m_wrap = 0; m_halted = 0;
      end else if (!m_halted && m_run && bus.en) begin
        if (m_step < 3) begin
          if (bus.mem_rdy) begin
            if (m_step == 2) m_c = int'(bus.mem_data);
            m_step++;
          end
        end else if (m_step == 3) begin
          m_step = 4;
        end else begin
          if (bus.leq) begin
            m_pc = m_c;
            m_halted = (m_c == HALT_M);
          end else begin
            if (m_pc + STEP_M >= 256) m_wrap = 1;
            m_pc = (m_pc + STEP_M) % 256;
          end
          m_step = 0;
        end
      end
      m_run = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      bit fetching;
      fetching = m_run && !m_halted && (m_step < 3);
      chk("pc", int'(bus.pc), m_pc);
      chk("fetch_addr", int'(bus.fetch_addr), fetching ? (m_pc + m_step) % 256 : m_pc);
      chk("fetch_req", int'(bus.fetch_req), int'(fetching && bus.en));
      chk("opsel", int'(bus.opsel), fetching ? m_step : 3);
      chk("exec", int'(bus.exec), int'(m_run && !m_halted && m_step == 3 && bus.en));
      chk("halted", int'(bus.halted), int'(m_halted));
      chk("wrap", int'(bus.wrap), int'(m_wrap));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int addr);
    bus.load = 1'b1;
    bus.load_addr = 8'(addr);
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    bus.en = 1'b1; bus.mem_rdy = 1'b1; bus.mem_data = 8'h20;
    bus.leq = 1'b0; bus.load = 1'b0; bus.load_addr = '0;
    #2 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    tick(); tick();
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_req", int'(bus.fetch_req), 0);
    chk("rst_opsel", int'(bus.opsel), 3);
    rst_n = 1'b1;
    #1 chk("rel_req_held", int'(bus.fetch_req), 0);

    // first instruction from reset
    tick(); chk("i1_fa0", int'(bus.fetch_addr), 8'h00); chk("i1_req", int'(bus.fetch_req), 1);
    tick(); chk("i1_fa1", int'(bus.fetch_addr), 8'h01);
    tick(); chk("i1_fa2", int'(bus.fetch_addr), 8'h02);
    tick(); chk("i1_exec", int'(bus.exec), 1);
    tick(); chk("i1_exec_off", int'(bus.exec), 0);
    tick(); chk("i1_pc", int'(bus.pc), 8'h03);

    // taken branch
    do_load(8'h10);
    bus.mem_data = 8'h40; bus.leq = 1'b1;
    repeat (5) tick();
    chk("br_pc", int'(bus.pc), 8'h40); chk("br_wrap", int'(bus.wrap), 0);
    bus.leq = 1'b0;

    // sequential wrap
    do_load(8'hFE);
    chk("wr_fa0", int'(bus.fetch_addr), 8'hFE);
    tick(); chk("wr_fa1", int'(bus.fetch_addr), 8'hFF);
    tick(); chk("wr_fa2", int'(bus.fetch_addr), 8'h00);
    tick(); tick(); tick();
    chk("wr_pc", int'(bus.pc), 8'h01); chk("wr_wrap", int'(bus.wrap), 1);
    repeat (5) tick();
    chk("wr_pc2", int'(bus.pc), 8'h04); chk("wr_sticky", int'(bus.wrap), 1);

    // halt
    bus.mem_data = 8'hFF; bus.leq = 1'b1;
    repeat (5) tick();
    chk("h_pc", int'(bus.pc), 8'hFF); chk("h_halted", int'(bus.halted), 1);
    for (int i = 0; i < 10; i++) begin
      tick(); chk("h_req_off", int'(bus.fetch_req), 0);
    end
    bus.leq = 1'b0;
    do_load(8'h08);
    chk("h_exit", int'(bus.halted), 0); chk("h_fa", int'(bus.fetch_addr), 8'h08);
    chk("h_wrap_clr", int'(bus.wrap), 0);

    // memory stall in FETCH_B, EN gap in EXECUTE
    tick();
    bus.mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("st_fa", int'(bus.fetch_addr), 8'h09); chk("st_opsel", int'(bus.opsel), 1);
    end
    bus.mem_rdy = 1'b1;
    tick(); tick();
    bus.en = 1'b0;
    #1 chk("eg_exec0", int'(bus.exec), 0);
    tick(); tick(); chk("eg_exec_hold", int'(bus.exec), 0);
    bus.en = 1'b1;
    #1 chk("eg_exec1", int'(bus.exec), 1);
    tick(); chk("eg_exec_once", int'(bus.exec), 0);
    tick(); chk("eg_pc", int'(bus.pc), 8'h0B);

    // abort by LOAD in FETCH_C
    tick(); tick();
    do_load(8'h30);
    chk("ab_pc", int'(bus.pc), 8'h30); chk("ab_opsel", int'(bus.opsel), 0);
    chk("ab_exec", int'(bus.exec), 0);

    // asynchronous reset in EXECUTE
    tick(); tick(); tick();
    chk("ar_exec_pre", int'(bus.exec), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pc", int'(bus.pc), 0); chk("ar_req", int'(bus.fetch_req), 0);
    chk("ar_opsel", int'(bus.opsel), 3); chk("ar_exec", int'(bus.exec), 0);
    chk("ar_halted", int'(bus.halted), 0); chk("ar_wrap", int'(bus.wrap), 0);
    tick(); tick();
    rst_n = 1'b1;

    // mixed enable/ready/branch patterns checked by the model
    for (int i = 0; i < 80; i++) begin
      bus.en       = (i % 7) != 3;
      bus.mem_rdy  = (i % 5) != 1;
      bus.leq      = (i % 11) == 4;
      bus.mem_data = 8'((i * 37) % 255);
      bus.load     = (i == 40);
      bus.load_addr = 8'hF9;
      tick();
    end
    bus.load = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: width of PC, fetch address, operand C and LOAD_ADDR.
REQ-002 Parameter RESET_PC, default 0: PC value on reset.
REQ-003 Parameter STEP, default 3: sequential PC increment per instruction; legal range 3..2^ADDR_W-1.
REQ-004 Parameter HALT_ADDR, default all ones: a taken branch to this address halts the sequencer.
REQ-005 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-006 RST_N  in  1  reset, asynchronous and active-low.
REQ-007 EN  in  1  advance enable; 0 freezes state, PC and the operand register.
REQ-008 MEM_RDY  in  1  memory read data valid for the current FETCH_ADDR.
REQ-009 MEM_DATA  in  ADDR_W  memory read data; only the operand C fetch uses it.
REQ-010 LEQ  in  1  datapath result <= 0; valid in the UPDATE state.
REQ-011 LOAD  in  1  synchronous PC load request.
REQ-012 LOAD_ADDR  in  ADDR_W  address written to PC when LOAD=1.
REQ-013 PC  out  ADDR_W  base address of the current instruction.
REQ-014 FETCH_ADDR  out  ADDR_W  operand address presented to memory.
REQ-015 FETCH_REQ  out  1  memory read request.
REQ-016 OPSEL  out  2  operand being fetched: 0=A, 1=B, 2=C, 3=none.
REQ-017 EXEC  out  1  one-cycle pulse that tells the datapath to perform the subtract and write-back.
REQ-018 HALTED  out  1  the sequencer is in the HALT state.
REQ-019 WRAP  out  1  sticky flag: a sequential PC update overflowed 2^ADDR_W.

Function
REQ-020 The FSM SHALL have the states FETCH_A, FETCH_B, FETCH_C, EXECUTE, UPDATE and HALT.
REQ-021 FETCH_A/B/C SHALL drive FETCH_REQ=EN, OPSEL=0/1/2 and FETCH_ADDR=PC, PC+1 or PC+2 respectively, all modulo 2^ADDR_W.
REQ-022 A fetch state SHALL advance to the next state only on a cycle with EN=1 and MEM_RDY=1; otherwise it holds, with no timeout.
REQ-023 On the advancing cycle of FETCH_C the block SHALL latch MEM_DATA into the internal operand register c_reg.
REQ-024 EXECUTE SHALL assert EXEC=1 for exactly one cycle with EN=1, then go to UPDATE.
- While EN=0 in EXECUTE: EXEC=0 and the state holds.
REQ-025 UPDATE with EN=1 SHALL do the following:
- LEQ=1: PC<=c_reg.
- LEQ=0: PC<=(PC+STEP) mod 2^ADDR_W.
- Then go to FETCH_A.
REQ-026 In UPDATE, if LEQ=1 and c_reg==HALT_ADDR, PC SHALL still load c_reg, and the next state SHALL be HALT instead of FETCH_A.
REQ-027 HALT SHALL hold PC and set HALTED=1, FETCH_REQ=0, EXEC=0 and OPSEL=3; only LOAD or reset leaves HALT.
REQ-028 In all non-fetch states, FETCH_REQ=0, OPSEL=3 and FETCH_ADDR=PC.
REQ-029 WRAP SHALL set when a LEQ=0 update produces PC+STEP >= 2^ADDR_W.
- Branch loads and operand address wrap (PC+1, PC+2) SHALL NOT set WRAP.
- WRAP clears only on LOAD or reset.
REQ-030 LOAD=1 SHALL take priority over EN and over every state. On that edge: PC<=LOAD_ADDR, state<=FETCH_A, WRAP<=0, HALTED<=0.
- Any instruction in progress is aborted, with no EXEC and no PC update from it.
REQ-031 Latency: with EN=1 and MEM_RDY=1 held, one instruction SHALL take exactly 5 cycles (FETCH_A to the next FETCH_A).
REQ-032 EXEC SHALL never be asserted in two consecutive cycles.

Reset
REQ-033 While RST_N=0, outputs SHALL be: PC=RESET_PC, FETCH_ADDR=RESET_PC, FETCH_REQ=0, OPSEL=3, EXEC=0, HALTED=0, WRAP=0.
- c_reg SHALL be 0 and the state FETCH_A.
REQ-034 An internal run flop SHALL hold FETCH_REQ at 0 until the first rising CLK edge after RST_N deasserts, so the first request appears one cycle after release.
REQ-035 Reset asserted in any state, including HALT or mid-EXECUTE, SHALL take effect immediately without a clock; no EXEC pulse is emitted.

Verification
REQ-036 Defaults; RST_N released; EN=1, MEM_RDY=1; C data=0x20; LEQ=0
- FETCH_ADDR sequence 0x00, 0x01, 0x02.
- EXEC pulses on cycle 4.
- PC=0x03 at cycle 5.
REQ-037 PC=0x10, C data=0x40, LEQ=1 in UPDATE -> PC=0x40 after UPDATE; WRAP=0.
REQ-038 PC=0xFE, LEQ=0 -> fetch addresses 0xFE, 0xFF, 0x00; PC becomes 0x01; WRAP=1 and stays 1 until LOAD.
REQ-039 C data=0xFF, LEQ=1 -> PC=0xFF and HALTED=1.
- Next cycle: FETCH_REQ=0, and it stays 0 for 10 cycles.
- LOAD=1 with LOAD_ADDR=0x08 -> HALTED=0, FETCH_ADDR=0x08.
REQ-040 MEM_RDY=0 for 3 cycles in FETCH_B -> FETCH_ADDR stays PC+1 with OPSEL=1; EN=0 in EXECUTE delays the EXEC pulse until EN returns.
REQ-041 LOAD=1 with LOAD_ADDR=0x30 during FETCH_C, or RST_N=0 during EXECUTE
- LOAD case: FETCH_A at 0x30 with no EXEC.
- Reset case: all outputs take their reset values asynchronously.
